// File: rtl/uart_tx_arb_pkg.sv
// Shared constants for the UART transmit arbiter: default parameters and FSM encoding.
package uart_tx_arb_pkg;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_LEN_W   = 4;
   localparam int DEF_DBIT    = 8;
   localparam int DEF_TIMEOUT = 255;

   // Two-state FSM, kept as plain constants so older tools can consume them.
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping around.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          valid
);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      logic [PW-1:0] j;
      grant = '0;
      valid = 1'b0;
      j     = '0;
      for (int i = 0; i < N; i++) begin
         j = PW'((int'(ptr) + i) % N);
         if (!valid && req[j]) begin
            grant[j] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// UART transmit arbiter: round-robin ownership of the TX FIFO by whole messages,
// with an idle timeout that reclaims the path from a stalled owner.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int DBIT    = DEF_DBIT,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
`ifdef USE_POWER_PINS
   inout  wire                      vccd1,
   inout  wire                      vssd1,
`endif
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*LEN_W-1:0]   len_i,
   input  logic [N_REQ*DBIT-1:0]    data_i,
   input  logic [N_REQ-1:0]         valid_i,
   output logic [N_REQ-1:0]         ready_o,
   output logic [N_REQ-1:0]         grant_o,
   output logic [N_REQ-1:0]         done_o,
   output logic [N_REQ-1:0]         abort_o,
   output logic                     busy_o,
   input  logic                     tx_full,
   output logic                     wr_uart,
   output logic [DBIT-1:0]          w_data
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int IW = $clog2(TIMEOUT + 1);

   logic [0:0]       state;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    own;
   logic [LEN_W-1:0] cnt;
   logic [IW-1:0]    idle_cnt;

   logic [N_REQ-1:0] pick_grant;
   logic             pick_valid;
   logic [PW-1:0]    pick_idx;
   logic [N_REQ-1:0] own_oh;
   logic [PW-1:0]    next_ptr;
   logic             xfer, own_valid, accept, last, timeout;

   rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   // One-hot pick to index, used to latch the owner.
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (pick_grant[i]) pick_idx = PW'(i);
   end

   assign xfer      = (state == XFER);
   assign own_valid = valid_i[own];
   assign accept    = xfer && own_valid && !tx_full;
   assign last      = accept && (cnt == '0);
   // A tx_full stall with valid high is not idleness; only missing data counts.
   assign timeout   = xfer && !own_valid && (idle_cnt == IW'(TIMEOUT - 1));
   assign next_ptr  = (own == PW'(N_REQ - 1)) ? '0 : own + 1'b1;

   // Owner one-hot; everything owner-specific is gated by XFER so reset zeroes it.
   always_comb begin
      own_oh = '0;
      if (xfer) own_oh[own] = 1'b1;
   end

   assign grant_o = own_oh;
   assign ready_o = accept  ? own_oh : '0;
   assign done_o  = last    ? own_oh : '0;
   assign abort_o = timeout ? own_oh : '0;
   assign busy_o  = xfer;
   assign wr_uart = accept;
   assign w_data  = xfer ? data_i[int'(own)*DBIT +: DBIT] : '0;

   // Arbitration FSM: grant in IDLE, stream bytes in XFER until last byte or timeout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         own      <= '0;
         cnt      <= '0;
         idle_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= XFER;
                  own      <= pick_idx;
                  cnt      <= len_i[int'(pick_idx)*LEN_W +: LEN_W];
                  idle_cnt <= '0;
               end
            end
            XFER: begin
               if (accept) begin
                  idle_cnt <= '0;
                  if (cnt == '0) begin
                     state  <= IDLE;
                     rr_ptr <= next_ptr;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end else if (timeout) begin
                  state    <= IDLE;
                  rr_ptr   <= next_ptr;
                  idle_cnt <= '0;
               end else if (!own_valid) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end else begin
                  idle_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
